// File: rtl/morse_pkg.sv
// Shared types and the ITU Morse code table for the Morse decoder.
// Symbol i of a character is code bit i; a dot is 0 and a dash is 1.
package morse_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SPACE_WAIT
  } state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_QMARK = 8'h3F;

  typedef struct packed {
    logic       err;
    logic [7:0] ch;
  } fifo_entry_t;

  // Codes here are written MSB-first, so each reads as the Morse pattern reversed.
  function automatic fifo_entry_t morse_lookup(input logic [2:0] len, input logic [6:0] code);
    logic [7:0] c;
    c = 8'h00;
    if (code[6:5] == 2'b00) begin
      unique case (len)
        3'd1: c = code[0] ? "T" : "E";
        3'd2: begin
          unique case (code[1:0])
            2'b00: c = "I";
            2'b01: c = "N";
            2'b10: c = "A";
            default: c = "M";
          endcase
        end
        3'd3: begin
          unique case (code[2:0])
            3'b000: c = "S";
            3'b001: c = "D";
            3'b010: c = "R";
            3'b011: c = "G";
            3'b100: c = "U";
            3'b101: c = "K";
            3'b110: c = "W";
            default: c = "O";
          endcase
        end
        3'd4: begin
          unique case (code[3:0])
            4'b0000: c = "H";
            4'b0001: c = "B";
            4'b0010: c = "L";
            4'b0011: c = "Z";
            4'b0100: c = "F";
            4'b0101: c = "C";
            4'b0110: c = "P";
            4'b1000: c = "V";
            4'b1001: c = "X";
            4'b1011: c = "Q";
            4'b1101: c = "Y";
            4'b1110: c = "J";
            default: c = 8'h00;
          endcase
        end
        3'd5: begin
          unique case (code[4:0])
            5'b11111: c = "0";
            5'b11110: c = "1";
            5'b11100: c = "2";
            5'b11000: c = "3";
            5'b10000: c = "4";
            5'b00000: c = "5";
            5'b00001: c = "6";
            5'b00011: c = "7";
            5'b00111: c = "8";
            5'b01111: c = "9";
            default: c = 8'h00;
          endcase
        end
        default: c = 8'h00;
      endcase
    end
    morse_lookup = (c == 8'h00) ? {1'b1, CH_QMARK} : {1'b0, c};
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Synchronous FIFO of decoded {err, char} entries; a push into a full FIFO
// only lands when a pop frees the head slot on the same edge.
module morse_char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [8:0] wdata_i,
  input  logic       pop_i,
  output logic [8:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse-to-ASCII decoder: collects dot/dash symbols, commits on done or an
// idle letter gap, optionally emits a word space, and queues characters out.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int MAX_SYMS   = 6,
  parameter int LETTER_GAP = 0,
  parameter int WORD_GAP   = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_W      = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dot_pulse,
  input  logic                          dash_pulse,
  input  logic                          done_pulse,
  output logic [7:0]                    out_char,
  output logic                          out_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(MAX_SYMS+1)-1:0] sym_count,
  output logic                          drop
);
  localparam int CNT_W = $clog2(MAX_SYMS+1);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_SYMS);
  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [GAP_W-1:0] LGAP    = GAP_W'(LETTER_GAP);
  localparam logic [GAP_W-1:0] WGAP    = GAP_W'(WORD_GAP);
  localparam logic [GAP_W-1:0] LGAP_M1 = GAP_W'(LETTER_GAP - 1);
  localparam logic [GAP_W-1:0] WGAP_M1 = GAP_W'(WORD_GAP - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [MAX_SYMS-1:0]   code_q, code_d;
  logic                  ovf_q, ovf_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  drop_q, drop_d;

  logic                  sym, commit, push, pop, fifo_full, fifo_empty;
  logic [MAX_SYMS-1:0]   sym_vec;
  fifo_entry_t           push_data, head;

  assign sym     = dot_pulse | dash_pulse;
  assign sym_vec = {{(MAX_SYMS-1){1'b0}}, dash_pulse};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      gap_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    code_d    = code_q;
    ovf_d     = ovf_q;
    gap_d     = gap_q;
    commit    = 1'b0;
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (done_pulse) begin
          push      = 1'b1;
          push_data = {1'b0, CH_SPACE};
        end else if (sym) begin
          state_d = S_COLLECT;
          len_d   = LEN_ONE;
          code_d  = sym_vec;
        end
      end
      S_COLLECT: begin
        if (gap_q != LGAP) gap_d = gap_q + GAP_ONE;
        if (done_pulse) begin
          commit = 1'b1;
        end else if (sym) begin
          // Symbols beyond MAX_SYMS are dropped but poison the character.
          if (len_q != LEN_MAX) begin
            code_d = code_q | (sym_vec << len_q);
            len_d  = len_q + LEN_ONE;
            gap_d  = '0;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (LETTER_GAP != 0 && gap_q == LGAP_M1) begin
          commit = 1'b1;
        end
      end
      S_SPACE_WAIT: begin
        if (gap_q != WGAP) gap_d = gap_q + GAP_ONE;
        if (done_pulse) begin
          push      = 1'b1;
          push_data = {1'b0, CH_SPACE};
          state_d   = S_IDLE;
          gap_d     = '0;
        end else if (sym) begin
          state_d = S_COLLECT;
          len_d   = LEN_ONE;
          code_d  = sym_vec;
          gap_d   = '0;
        end else if (WORD_GAP != 0 && gap_q == WGAP_M1) begin
          push      = 1'b1;
          push_data = {1'b0, CH_SPACE};
          state_d   = S_IDLE;
          gap_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      push      = 1'b1;
      push_data = ovf_q ? {1'b1, CH_QMARK} : morse_lookup(3'(len_q), 7'(code_q));
      len_d     = '0;
      code_d    = '0;
      ovf_d     = 1'b0;
      gap_d     = '0;
      state_d   = (WORD_GAP != 0) ? S_SPACE_WAIT : S_IDLE;
    end
  end

  assign pop    = out_valid && out_ready;
  assign drop_d = push && fifo_full && !pop;

  morse_char_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_char  = out_valid ? head.ch : 8'h00;
  assign out_err   = out_valid & head.err;
  assign sym_count = len_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed scenarios plus randomized characters
// checked against a pattern-string model of the ITU code table.
module tb_morse_decoder;
  localparam int MS = 6;
  localparam int LG = 8;
  localparam int WG = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dot0, dash0, done0, rdy0, err0, vld0, drop0;
  logic       dot1, dash1, done1, rdy1, err1, vld1, drop1;
  logic [7:0] ch0, ch1;
  logic [2:0] cnt0, cnt1;

  morse_decoder #(.MAX_SYMS(MS), .LETTER_GAP(0), .WORD_GAP(0), .FIFO_DEPTH(4), .GAP_W(24)) u0 (
    .clk(clk), .reset(rst), .dot_pulse(dot0), .dash_pulse(dash0), .done_pulse(done0),
    .out_char(ch0), .out_err(err0), .out_valid(vld0), .out_ready(rdy0),
    .sym_count(cnt0), .drop(drop0));

  morse_decoder #(.MAX_SYMS(MS), .LETTER_GAP(LG), .WORD_GAP(WG), .FIFO_DEPTH(4), .GAP_W(24)) u1 (
    .clk(clk), .reset(rst), .dot_pulse(dot1), .dash_pulse(dash1), .done_pulse(done1),
    .out_char(ch1), .out_err(err1), .out_valid(vld1), .out_ready(rdy1),
    .sym_count(cnt1), .drop(drop1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int drops0  = 0;
  logic [8:0] rx0[$];
  logic [8:0] rx1[$];
  int         rx1_t[$];

  string mtab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                      "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  always @(posedge clk) cyc <= cyc + 1;

  // Entries seen valid&&ready at the falling edge are popped on the next rising edge.
  always @(negedge clk) begin
    if (vld0 && rdy0) rx0.push_back({err0, ch0});
    if (drop0) drops0 = drops0 + 1;
    if (vld1 && rdy1) begin
      rx1.push_back({err1, ch1});
      rx1_t.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] model(input string p);
    if (p.len() > MS) return {1'b1, 8'h3F};
    for (int i = 0; i < 36; i++)
      if (p == mtab[i]) return {1'b0, (i < 26) ? 8'(65 + i) : 8'(48 + i - 26)};
    return {1'b1, 8'h3F};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic d, input logic s, input logic c);
    dot0 = d; dash0 = s; done0 = c;
    step();
    dot0 = 1'b0; dash0 = 1'b0; done0 = 1'b0;
  endtask

  task automatic drive1(input logic d, input logic s, input logic c);
    dot1 = d; dash1 = s; done1 = c;
    step();
    dot1 = 1'b0; dash1 = 1'b0; done1 = 1'b0;
  endtask

  task automatic char0(input string p);
    for (int i = 0; i < p.len(); i++) drive0(p[i] == ".", p[i] == "-", 1'b0);
    drive0(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    n_tests++; if (ch0 !== 8'h00) begin n_fail++; $display("FAIL reset_char got=%h exp=00", ch0); end
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err0); end
    n_tests++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", vld0); end
    n_tests++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    n_tests++; if (drop0 !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b exp=0", drop0); end
    n_tests++; if ({vld1, cnt1, ch1} !== 12'h000) begin n_fail++; $display("FAIL reset_u1 got=%h exp=000", {vld1, cnt1, ch1}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    rdy0 = 1'b1;
    drive0(1'b1, 1'b0, 1'b0);
    n_tests++; if (cnt0 !== 3'd1) begin n_fail++; $display("FAIL basic_count1 got=%0d exp=1", cnt0); end
    drive0(1'b0, 1'b1, 1'b0);
    n_tests++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL basic_count2 got=%0d exp=2", cnt0); end
    drive0(1'b0, 1'b0, 1'b1);
    n_tests++; if ({vld0, err0, ch0} !== {2'b10, 8'h41}) begin n_fail++; $display("FAIL basic_A got=%b%b%h exp=1041", vld0, err0, ch0); end
    n_tests++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL basic_count0 got=%0d exp=0", cnt0); end
    step();
    n_tests++; if ({vld0, ch0} !== 9'h000) begin n_fail++; $display("FAIL basic_one_cycle got=%b%h exp=000", vld0, ch0); end
  endtask

  task automatic test_digits();
    char0("-----");
    n_tests++; if ({vld0, err0, ch0} !== {2'b10, 8'h30}) begin n_fail++; $display("FAIL digit0 got=%b%b%h exp=1030", vld0, err0, ch0); end
    step();
    char0(".----");
    n_tests++; if ({vld0, err0, ch0} !== {2'b10, 8'h31}) begin n_fail++; $display("FAIL digit1 got=%b%b%h exp=1031", vld0, err0, ch0); end
    step();
  endtask

  task automatic test_overflow();
    int peak;
    peak = 0;
    for (int i = 0; i < 7; i++) begin
      drive0(1'b1, 1'b0, 1'b0);
      if (int'(cnt0) > peak) peak = int'(cnt0);
      n_tests++; if (int'(cnt0) != ((i + 1 > MS) ? MS : i + 1)) begin n_fail++; $display("FAIL ovf_count%0d got=%0d exp=%0d", i, cnt0, (i + 1 > MS) ? MS : i + 1); end
    end
    n_tests++; if (peak != MS) begin n_fail++; $display("FAIL ovf_peak got=%0d exp=%0d", peak, MS); end
    drive0(1'b0, 1'b0, 1'b1);
    n_tests++; if ({vld0, err0, ch0} !== {2'b11, 8'h3F}) begin n_fail++; $display("FAIL ovf_entry got=%b%b%h exp=113f", vld0, err0, ch0); end
    step();
    char0("..--");
    n_tests++; if ({vld0, err0, ch0} !== {2'b11, 8'h3F}) begin n_fail++; $display("FAIL unmapped got=%b%b%h exp=113f", vld0, err0, ch0); end
    step();
  endtask

  task automatic test_collision();
    drive0(1'b1, 1'b0, 1'b0);
    drive0(1'b1, 1'b1, 1'b1);
    n_tests++; if ({vld0, err0, ch0, cnt0} !== {2'b10, 8'h45, 3'd0}) begin n_fail++; $display("FAIL collide_E got=%b%b%h/%0d exp=1045/0", vld0, err0, ch0, cnt0); end
    step();
    n_tests++; if ({vld0, cnt0} !== 4'h0) begin n_fail++; $display("FAIL collide_discard got=%b/%0d exp=0/0", vld0, cnt0); end
    drive0(1'b0, 1'b0, 1'b1);
    n_tests++; if ({vld0, err0, ch0} !== {2'b10, 8'h20}) begin n_fail++; $display("FAIL idle_space got=%b%b%h exp=1020", vld0, err0, ch0); end
    step();
  endtask

  task automatic test_reset_mid();
    rx0.delete();
    drive0(1'b1, 1'b0, 1'b0);
    drive0(1'b1, 1'b0, 1'b0);
    n_tests++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL mid_count got=%0d exp=2", cnt0); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if ({vld0, cnt0} !== 4'h0) begin n_fail++; $display("FAIL mid_cleared got=%b/%0d exp=0/0", vld0, cnt0); end
    char0("-");
    repeat (3) step();
    n_tests++; if (rx0.size() != 1) begin n_fail++; $display("FAIL mid_size got=%0d exp=1", rx0.size()); end
    else begin
      n_tests++; if (rx0[0] !== {1'b0, 8'h54}) begin n_fail++; $display("FAIL mid_T got=%h exp=054", rx0[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_q[$];
    exp_q = '{{1'b0, 8'h45}, {1'b0, 8'h54}, {1'b0, 8'h49}, {1'b0, 8'h4D}, {1'b0, 8'h41}};
    rdy0 = 1'b0; rx0.delete(); drops0 = 0;
    char0("."); char0("-"); char0(".."); char0("--");
    n_tests++; if (drops0 != 0) begin n_fail++; $display("FAIL bp_nodrop got=%0d exp=0", drops0); end
    char0(".-");
    n_tests++; if (drop0 !== 1'b1) begin n_fail++; $display("FAIL bp_drop got=%b exp=1", drop0); end
    step();
    n_tests++; if (drop0 !== 1'b0) begin n_fail++; $display("FAIL bp_drop_pulse got=%b exp=0", drop0); end
    rdy0 = 1'b1;
    repeat (6) step();
    n_tests++; if (drops0 != 1) begin n_fail++; $display("FAIL bp_drop_count got=%0d exp=1", drops0); end
    n_tests++; if (rx0.size() != 4) begin n_fail++; $display("FAIL bp_size got=%0d exp=4", rx0.size()); end
    for (int i = 0; i < 4 && i < rx0.size(); i++) begin
      n_tests++; if (rx0[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order%0d got=%h exp=%h", i, rx0[i], exp_q[i]); end
    end
    // Full FIFO plus a pop on the same edge as the push: nothing is lost.
    rdy0 = 1'b0; rx0.delete();
    char0("."); char0("-"); char0(".."); char0("--");
    drive0(1'b1, 1'b0, 1'b0);
    drive0(1'b0, 1'b1, 1'b0);
    rdy0 = 1'b1;
    drive0(1'b0, 1'b0, 1'b1);
    repeat (8) step();
    n_tests++; if (drops0 != 1) begin n_fail++; $display("FAIL bp_poppush_drop got=%0d exp=1", drops0); end
    n_tests++; if (rx0.size() != 5) begin n_fail++; $display("FAIL bp_poppush_size got=%0d exp=5", rx0.size()); end
    for (int i = 0; i < 5 && i < rx0.size(); i++) begin
      n_tests++; if (rx0[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_poppush%0d got=%h exp=%h", i, rx0[i], exp_q[i]); end
    end
  endtask

  task automatic test_auto_gap();
    int t;
    rdy1 = 1'b1; rx1.delete(); rx1_t.delete();
    drive1(1'b1, 1'b0, 1'b0);
    t = cyc;
    repeat (40) step();
    n_tests++; if (rx1.size() != 2) begin n_fail++; $display("FAIL gap_size got=%0d exp=2", rx1.size()); end
    else begin
      n_tests++; if (rx1[0] !== {1'b0, 8'h45} || rx1_t[0] != t + LG) begin n_fail++; $display("FAIL gap_letter got=%h@%0d exp=045@%0d", rx1[0], rx1_t[0], t + LG); end
      n_tests++; if (rx1[1] !== {1'b0, 8'h20} || rx1_t[1] != t + LG + WG) begin n_fail++; $display("FAIL gap_space got=%h@%0d exp=020@%0d", rx1[1], rx1_t[1], t + LG + WG); end
    end
    rx1.delete(); rx1_t.delete();
    drive1(1'b1, 1'b0, 1'b0);
    t = cyc;
    repeat (LG + WG - 2) step();
    drive1(1'b1, 1'b0, 1'b0);
    n_tests++; if (cnt1 !== 3'd1) begin n_fail++; $display("FAIL gap_late_dot got=%0d exp=1", cnt1); end
    repeat (5) step();
    n_tests++; if (rx1.size() != 1) begin n_fail++; $display("FAIL gap_no_space got=%0d exp=1", rx1.size()); end
    repeat (40) step();
    n_tests++; if (rx1.size() != 3) begin n_fail++; $display("FAIL gap_second_size got=%0d exp=3", rx1.size()); end
    else begin
      n_tests++; if (rx1[1] !== {1'b0, 8'h45} || rx1_t[1] != t + LG + WG - 1 + LG) begin n_fail++; $display("FAIL gap_second got=%h@%0d exp=045@%0d", rx1[1], rx1_t[1], t + LG + WG - 1 + LG); end
      n_tests++; if (rx1[2] !== {1'b0, 8'h20} || rx1_t[2] != t + 2 * LG + 2 * WG - 1) begin n_fail++; $display("FAIL gap_second_space got=%h@%0d exp=020@%0d", rx1[2], rx1_t[2], t + 2 * LG + 2 * WG - 1); end
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    string      p;
    int         len;
    bit         ds, both;
    rst = 1'b1; step(); rst = 1'b0;
    rdy0 = 1'b1; rx0.delete();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        drive0(1'b0, 1'b0, 1'b1);
        exp_q.push_back({1'b0, 8'h20});
      end else begin
        len = $urandom_range(1, 7);
        p = "";
        for (int i = 0; i < len; i++) begin
          ds   = 1'($urandom_range(0, 1));
          both = ($urandom_range(0, 5) == 0);
          repeat ($urandom_range(0, 2)) step();
          p = ds ? {p, "-"} : {p, "."};
          drive0(!ds || both, ds, 1'b0);
        end
        repeat ($urandom_range(0, 2)) step();
        drive0(1'b0, 1'b0, 1'b1);
        exp_q.push_back(model(p));
      end
    end
    repeat (4) step();
    n_tests++; if (rx0.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_size got=%0d exp=%0d", rx0.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx0.size(); i++) begin
      n_tests++; if (rx0[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_char%0d got=%h exp=%h", i, rx0[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    dot0 = 1'b0; dash0 = 1'b0; done0 = 1'b0; rdy0 = 1'b1;
    dot1 = 1'b0; dash1 = 1'b0; done1 = 1'b0; rdy1 = 1'b1;
    test_reset();
    test_basic();
    test_digits();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_backpressure();
    test_auto_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
